// File: rtl/rr_bus_arbiter4.sv
// Four-way round-robin arbiter feeding one registered output slot with valid/ready handshakes.
// Build option: define ARB_BURST_EN to let a winner keep priority for up to MAX_BURST words.
module rr_bus_arbiter4 #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_data2,
  input  logic [WIDTH-1:0] req_data3,
  output logic [3:0]       req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       out_src,
  output logic             busy
);

`ifdef ARB_BURST_EN
  localparam bit BurstEn = 1'b1;
`else
  localparam bit BurstEn = 1'b0;
`endif
  localparam logic [3:0] BurstLimit = 4'(MAX_BURST);

  logic [1:0]       last_grant_q, last_grant_d;
  logic [3:0]       burst_cnt_q, burst_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_src_q, out_src_d;

  logic             can_accept;
  logic             keep_prio;
  logic             found;
  logic             accept;
  logic [1:0]       search_base;
  logic [1:0]       winner;
  logic [WIDTH-1:0] win_data;

  assign can_accept = !out_valid_q || out_ready;

  // The current owner keeps first priority while its burst is open and it is still requesting.
  assign keep_prio = BurstEn && (burst_cnt_q != 4'd0) && (burst_cnt_q < BurstLimit)
                     && req_valid[last_grant_q];
  assign search_base = keep_prio ? last_grant_q : last_grant_q + 2'd1;

  // NOTE: every variable written in an always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    winner = search_base;
    found  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && req_valid[search_base + 2'(k)]) begin
        winner = search_base + 2'(k);
        found  = 1'b1;
      end
    end
  end

  // Grants are masked while reset is held so nothing looks accepted during reset.
  assign accept    = rst_n && can_accept && found;
  assign req_ready = accept ? (4'b0001 << winner) : 4'b0000;

  always_comb begin
    win_data = req_data0;
    unique case (winner)
      2'd0: win_data = req_data0;
      2'd1: win_data = req_data1;
      2'd2: win_data = req_data2;
      2'd3: win_data = req_data3;
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_data_d   = win_data;
      out_src_d    = winner;
      last_grant_d = winner;
      burst_cnt_d  = keep_prio ? burst_cnt_q + 4'd1 : 4'd1;
    end else begin
      if (out_ready) out_valid_d = 1'b0;
      if (!req_valid[last_grant_q]) burst_cnt_d = 4'd0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the data register is reset too, since its value is visible on out_data after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 2'd3;
      burst_cnt_q  <= 4'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= 2'd0;
    end else begin
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign busy      = out_valid_q || (|req_valid);

endmodule
